// File: rtl/phase_quadrant_ctrl.sv
// phase_quadrant_ctrl: walks the DCM fine phase one psen/psdone step at a time, then moves the clock-mux quadrant selects.
// Latency: N fine steps with psdone latency L give done N*(L+3)+3 cycles after fire, plus HOLD_CYCLES if the quadrant changes.
// Backpressure: at most one psen is outstanding per psdone, and fire edges are ignored while busy.
//
// Ports:
//   clock, global_reset         40 MHz clock, asynchronous active-high reset
//   fire, phase_target          start request (rising edge) and requested phase {hcycle, qcycle, fine}
//   dcm_locked, psdone          DCM lock status and phase-shift step acknowledge
//   psen, psincdec              DCM phase-shift enable pulse and direction
//   hcycle, qcycle              quadrant selects to the clock mux (registered, change only in QUAD)
//   phase_current               phase currently applied, same layout as phase_target
//   busy, done, timeout_err     status to the VME register logic
module phase_quadrant_ctrl #(
  parameter int FINE_BITS      = 6,
  parameter int HOLD_CYCLES    = 8,
  parameter int PSDONE_TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 global_reset,
  input  logic                 fire,
  input  logic [FINE_BITS+1:0] phase_target,
  input  logic                 dcm_locked,
  input  logic                 psdone,
  output logic                 psen,
  output logic                 psincdec,
  output logic                 hcycle,
  output logic                 qcycle,
  output logic [FINE_BITS+1:0] phase_current,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  // Counter widths; both counters count from zero up to a terminal value.
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TW = (PSDONE_TIMEOUT > 1) ? $clog2(PSDONE_TIMEOUT + 1) : 1;

  // HOLD lasts HOLD_CYCLES cycles: counter runs 0 .. HOLD_CYCLES-1.
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  // WAIT lasts at most PSDONE_TIMEOUT cycles: counter runs 0 .. PSDONE_TIMEOUT-1.
  localparam logic [TW-1:0] TO_LAST   = TW'(PSDONE_TIMEOUT - 1);

  // Sequencer states.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_STEP = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_QUAD = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]           r_state;
  logic                 r_fire_d;
  logic [FINE_BITS+1:0] r_target;
  logic [FINE_BITS-1:0] r_fine;
  logic                 r_hcycle;
  logic                 r_qcycle;
  logic                 r_psen;
  logic                 r_psincdec;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [TW-1:0]        r_to_cnt;
  logic [HW-1:0]        r_hold_cnt;

  logic                 w_fire_rise;
  logic                 w_lock_lost;
  logic [FINE_BITS-1:0] w_tgt_fine;
  logic [1:0]           w_tgt_quad;
  logic [1:0]           w_cur_quad;

  assign w_fire_rise = fire & ~r_fire_d;
  // Losing lock only matters while a sequence is running; in IDLE it is
  // reported when someone actually asks for a phase move.
  assign w_lock_lost = (r_state != S_IDLE) && !dcm_locked;
  assign w_tgt_fine  = r_target[FINE_BITS-1:0];
  assign w_tgt_quad  = r_target[FINE_BITS+1:FINE_BITS];
  assign w_cur_quad  = {r_hcycle, r_qcycle};

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      r_state    <= S_IDLE;
      // Reset high so a fire already held high through reset is not an edge.
      r_fire_d   <= 1'b1;
      r_target   <= '0;
      r_fine     <= '0;
      r_hcycle   <= 1'b0;
      r_qcycle   <= 1'b0;
      r_psen     <= 1'b0;
      r_psincdec <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_to_cnt   <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_fire_d <= fire;
      // psen and done are single-cycle pulses by default.
      r_psen   <= 1'b0;
      r_done   <= 1'b0;

      if (w_lock_lost) begin
        // Abort: phase_current keeps only acknowledged steps, no new psen.
        r_err   <= 1'b1;
        r_busy  <= 1'b0;
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_fire_rise) begin
              if (dcm_locked) begin
                r_target <= phase_target;
                r_err    <= 1'b0;
                r_busy   <= 1'b1;
                r_state  <= S_CALC;
              end else begin
                r_err    <= 1'b1;
              end
            end
          end

          S_CALC: begin
            // Plain unsigned distance; the fine field never wraps.
            if (w_tgt_fine == r_fine) begin
              r_state <= S_QUAD;
            end else begin
              r_psincdec <= (w_tgt_fine > r_fine);
              r_state    <= S_STEP;
            end
          end

          S_STEP: begin
            // psen appears in the first WAIT cycle, so the timeout window
            // starts together with the pulse the DCM actually sees.
            r_psen   <= 1'b1;
            r_to_cnt <= '0;
            r_state  <= S_WAIT;
          end

          S_WAIT: begin
            // psdone is checked first so a late acknowledge on the last
            // timeout cycle still counts as success.
            if (psdone) begin
              if (r_psincdec) begin
                r_fine <= r_fine + 1'b1;
              end else begin
                r_fine <= r_fine - 1'b1;
              end
              r_state <= S_CALC;
            end else if (r_to_cnt == TO_LAST) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end

          S_QUAD: begin
            if (w_tgt_quad == w_cur_quad) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              // The mux needs settle time to carry the new select into the
              // 4x domain before anyone relies on the new phase.
              r_hcycle   <= w_tgt_quad[1];
              r_qcycle   <= w_tgt_quad[0];
              r_hold_cnt <= '0;
              r_state    <= S_HOLD;
            end
          end

          S_HOLD: begin
            if (r_hold_cnt == HOLD_LAST) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end

          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end

          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // The quadrant half of phase_current is the mux select itself, so the
  // reported phase can never disagree with what the mux is using.
  assign phase_current = {r_hcycle, r_qcycle, r_fine};
  assign psen          = r_psen;
  assign psincdec      = r_psincdec;
  assign hcycle        = r_hcycle;
  assign qcycle        = r_qcycle;
  assign busy          = r_busy;
  assign done          = r_done;
  assign timeout_err   = r_err;

endmodule

// File: tb/tb_phase_quadrant_ctrl.sv
`timescale 1ns/1ps
module tb_phase_quadrant_ctrl;

  localparam int FB     = 6;
  localparam int HOLD_C = 8;
  localparam int PS_TO  = 255;

  typedef struct {
    bit        is_err;
    logic [7:0] phase;
    int        fire_cyc;
    int        lat;
    int        tol;   // negative: latency not checked
  } end_t;

  logic        clock = 1'b0;
  logic        global_reset;
  logic        fire;
  logic [7:0]  phase_target;
  logic        dcm_locked;
  logic        psdone = 1'b0;
  logic        psen;
  logic        psincdec;
  logic        hcycle;
  logic        qcycle;
  logic [7:0]  phase_current;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  bit   exp_dir_q[$];
  end_t exp_end_q[$];
  logic [7:0] model_phase = 8'h00;

  // DCM model controls
  int   ps_lat = 4;
  bit   ps_withhold = 1'b0;
  bit   ps_pend = 1'b0;
  int   ps_cd = 0;
  int   psdone_cnt = 0;
  bit   err_prev = 1'b0;

  phase_quadrant_ctrl #(
    .FINE_BITS(FB), .HOLD_CYCLES(HOLD_C), .PSDONE_TIMEOUT(PS_TO)
  ) dut (
    .clock(clock), .global_reset(global_reset), .fire(fire),
    .phase_target(phase_target), .dcm_locked(dcm_locked), .psdone(psdone),
    .psen(psen), .psincdec(psincdec), .hcycle(hcycle), .qcycle(qcycle),
    .phase_current(phase_current), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );

  always #12.5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_chk++;
    if (got < lo || got > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // DCM behaviour plus output monitor, all sampled on the falling edge.
  always @(negedge clock) begin
    bit   was_pend;
    bit   d;
    end_t r;
    was_pend = ps_pend;
    psdone = 1'b0;
    if (ps_pend) begin
      ps_cd--;
      if (ps_cd == 0) begin
        psdone = 1'b1;
        ps_pend = 1'b0;
        psdone_cnt++;
      end
    end
    if (!global_reset) begin
      if (psen) begin
        check("psen_outstanding", was_pend, 0);
        if (!ps_withhold) begin
          ps_pend = 1'b1;
          ps_cd = ps_lat;
        end
        n_chk++;
        if (exp_dir_q.size() == 0) begin
          n_fail++;
          $display("FAIL psen_unexpected: psen=1 psincdec=%0d, required no psen", psincdec);
        end else begin
          d = exp_dir_q.pop_front();
          check("psincdec", psincdec, d);
        end
      end
      if (done || (timeout_err && !err_prev)) begin
        n_chk++;
        if (exp_end_q.size() == 0) begin
          n_fail++;
          $display("FAIL end_unexpected: done=%0d timeout_err=%0d, required none", done, timeout_err);
        end else begin
          r = exp_end_q.pop_front();
          check("end_kind_is_err", !done, r.is_err);
          check("phase_current", phase_current, r.phase);
          check("hcycle", hcycle, r.phase[7]);
          check("qcycle", qcycle, r.phase[6]);
          check("busy_at_end", busy, !r.is_err);
          if (!r.is_err) check("timeout_err_clear", timeout_err, 0);
          if (r.tol >= 0)
            check_range("latency", cyc - r.fire_cyc, r.lat - r.tol, r.lat + r.tol);
        end
      end
      err_prev = timeout_err;
    end
  end

  // mode 0 normal, 1 withhold psdone, 2 drop lock after two steps,
  // 3 extra fire while busy, 4 fire while unlocked
  task automatic request(input logic [7:0] tgt, input int lat_l, input int mode);
    end_t r;
    int cf, tf, n, nf, base, k;
    bit up, qchg;
    cf = int'(model_phase[FB-1:0]);
    tf = int'(tgt[FB-1:0]);
    up = (tf > cf);
    n = up ? tf - cf : cf - tf;
    qchg = (tgt[7:6] != model_phase[7:6]);
    ps_lat = lat_l;
    ps_withhold = (mode == 1);
    r.is_err = 1'b0; r.phase = tgt; r.lat = 0; r.tol = 1; r.fire_cyc = 0;
    case (mode)
      0, 3: begin
        for (int i = 0; i < n; i++) exp_dir_q.push_back(up);
        r.lat = n * (lat_l + 3) + 3 + (qchg ? HOLD_C : 0);
        model_phase = tgt;
      end
      1: begin
        exp_dir_q.push_back(up);
        r.is_err = 1'b1; r.phase = model_phase; r.lat = PS_TO + 3; r.tol = 3;
      end
      2: begin
        exp_dir_q.push_back(up);
        exp_dir_q.push_back(up);
        nf = up ? cf + 2 : cf - 2;
        r.is_err = 1'b1; r.phase = {model_phase[7:6], 6'(nf)}; r.tol = -1;
        model_phase = r.phase;
      end
      default: begin
        r.is_err = 1'b1; r.phase = model_phase; r.lat = 1; r.tol = 1;
      end
    endcase
    base = psdone_cnt;
    @(negedge clock);
    phase_target = tgt;
    if (mode == 4) dcm_locked = 1'b0;
    r.fire_cyc = cyc;
    exp_end_q.push_back(r);
    fire = 1'b1;
    @(negedge clock);
    fire = 1'b0;
    if (mode == 3) begin
      repeat (3) @(negedge clock);
      phase_target = ~tgt;
      fire = 1'b1;
      @(negedge clock);
      fire = 1'b0;
    end
    if (mode == 2) begin
      k = 0;
      while (psdone_cnt < base + 2 && k < 2000) begin
        @(posedge clock);
        k++;
      end
      @(negedge clock);
      dcm_locked = 1'b0;
    end
    k = 0;
    while (exp_end_q.size() != 0 && k < 3000) begin
      @(negedge clock);
      k++;
    end
    check("sequence_completed", exp_end_q.size(), 0);
    exp_end_q.delete();
    repeat (3) @(negedge clock);
    check("psen_count", exp_dir_q.size(), 0);
    exp_dir_q.delete();
    dcm_locked = 1'b1;
    ps_withhold = 1'b0;
  endtask

  initial begin
    logic [7:0] t;
    int l;
    global_reset = 1'b1;
    fire = 1'b1;
    dcm_locked = 1'b1;
    phase_target = 8'h00;
    repeat (3) @(negedge clock);
    global_reset = 1'b0;
    repeat (5) @(negedge clock);
    check("rst_psen", psen, 0);
    check("rst_psincdec", psincdec, 0);
    check("rst_hcycle", hcycle, 0);
    check("rst_qcycle", qcycle, 0);
    check("rst_phase_current", phase_current, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout_err", timeout_err, 0);
    fire = 1'b0;
    repeat (2) @(negedge clock);

    request(8'h45, 4, 0);   // 5 increments, quadrant 00 -> 01
    request(8'h82, 4, 0);   // 3 decrements, quadrant 01 -> 10
    request(8'h82, 3, 0);   // nothing to do
    request(8'h8A, 4, 1);   // psdone withheld -> timeout
    request(8'h82, 2, 0);   // clears timeout_err
    request(8'h82, 2, 4);   // fire while unlocked
    request(8'h00, 3, 0);
    request(8'h05, 4, 2);   // lock lost after two steps
    request(8'h47, 3, 3);   // second fire while busy is ignored

    for (int i = 0; i < 10; i++) begin
      t = 8'($urandom_range(0, 255));
      l = $urandom_range(1, 6);
      request(t, l, 0);
    end

    check("final_phase", phase_current, model_phase);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_quadrant_ctrl.md
Name: phase_quadrant_ctrl

Overview:
- Control-side partner of the quadrant clock multiplexer. Drives its half-cycle and quarter-cycle quadrant selects.
- Also sequences the DCM fine phase-shift handshake (psen/psincdec/psdone) so a requested phase value moves to the clock outputs in a controlled way.
- Sits in the 40 MHz domain beside each phase-shifted DCM. Exposes the current phase and status to the VME register logic.

Parameters:
- FINE_BITS, 6: width of the fine-step field of the phase word.
- HOLD_CYCLES, 8: settle cycles after a quadrant change. Covers the mux's 3-flop transfer into the 4x domain (≥ 1 clock cycle).
- PSDONE_TIMEOUT, 255: clock cycles to wait for psdone before flagging an error.

Ports:
- clock  in  1  40 MHz main clock
- global_reset  in  1  asynchronous active-high reset
- fire  in  1  start request, acted on at its rising edge
- phase_target  in  FINE_BITS+2  requested phase: [FINE_BITS+1]=hcycle, [FINE_BITS]=qcycle, [FINE_BITS-1:0]=fine step
- dcm_locked  in  1  DCM lock status
- psdone  in  1  DCM phase-shift step complete, one-cycle pulse
- psen  out  1  DCM phase-shift enable, one-cycle pulse
- psincdec  out  1  DCM direction: 1=increment, 0=decrement
- hcycle  out  1  half-cycle quadrant select, to the clock mux
- qcycle  out  1  quarter-cycle quadrant select, to the clock mux
- phase_current  out  FINE_BITS+2  phase currently applied, same format as phase_target
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on successful completion
- timeout_err  out  1  sticky: psdone timeout or lock loss during a sequence; cleared by the next accepted fire

Behaviour:
- Reset values (async assert, all outputs): psen=0, psincdec=0, hcycle=0, qcycle=0, phase_current=0, busy=0, done=0, timeout_err=0, state=IDLE.
- fire edge detection: previous-fire register resets to 1, so a fire held high through reset does not trigger.
- IDLE:
  - On a fire rising edge with dcm_locked=1: latch phase_target into target_reg, clear timeout_err, go to CALC. busy=1 from the next cycle.
  - On a fire edge with dcm_locked=0: ignore the request and set timeout_err=1.
  - fire edges while busy are ignored.
- CALC: compare fine(target_reg) with fine(phase_current).
  - Equal: go to QUAD.
  - Target greater: psincdec=1, go to STEP.
  - Target less: psincdec=0, go to STEP.
  - Unsigned compare, no wraparound: moving from 0 to the maximum takes 2^FINE_BITS-1 increment steps.
- STEP: assert psen for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT:
  - psdone=1: adjust the fine field of phase_current by ±1, go to CALC.
  - Timeout counter reaches PSDONE_TIMEOUT: set timeout_err, go to IDLE with hcycle/qcycle unchanged.
  - psdone arriving on the same cycle as the timeout wins; no error is flagged.
- QUAD:
  - Quadrant bits of target equal to current: go to DONE without a hold.
  - Otherwise: update hcycle/qcycle and the quadrant field of phase_current in the same cycle, go to HOLD.
- HOLD: count HOLD_CYCLES cycles, then go to DONE.
- DONE: done=1 for one cycle, busy=0 from the next cycle, go to IDLE.
- Lock loss: dcm_locked=0 in any state other than IDLE sets timeout_err and returns to IDLE next cycle. phase_current keeps the last acknowledged value; no psen is issued.
- psen is never asserted while a step is outstanding, i.e. at most one psen per psdone.
- Latency for a request needing N fine steps and a quadrant change, with psdone latency L after psen:
  - done pulses N*(L+3)+HOLD_CYCLES+3 cycles after the fire edge, ±1 cycle.
  - Zero steps and no quadrant change: done 3 cycles after the fire edge.
- hcycle/qcycle are registered outputs, glitch-free, changing only in QUAD.

Test Plan:
- Reset with fire held at 1, release reset → no sequence starts; all outputs 0; busy stays 0.
- phase_target=0x45 from 0, psdone 4 cycles after each psen → 5 psen pulses with psincdec=1; hcycle=0, qcycle=1 after the 5th psdone; done once after HOLD; phase_current=0x45.
- From 0x45, request 0x82 → 3 decrement steps, hcycle=1, qcycle=0, phase_current=0x82, one done pulse.
- Request equal to phase_current → no psen; done 3 cycles after fire; hcycle/qcycle unchanged.
- Withhold psdone after the first psen → timeout_err=1 after 255 cycles, busy=0, fine field unchanged; next fire clears timeout_err.
- Drop dcm_locked mid-sequence after 2 of 5 steps → timeout_err=1, return to IDLE, phase_current fine field=2, no further psen; a second fire while busy in another run is ignored.
